// File: rtl/fifo_stream_reader_if.sv
// FIFO pop side and valid/ready stream side of the FIFO drain stage.
// master = the reader stage, slave = FIFO + downstream consumer.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd, m_valid, m_data
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO (pop strobe, data one cycle later) into a valid/ready stream
// through a 2-entry skid buffer; counts accepted words.
module fifo_stream_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    fifo_stream_reader_if.master   bus,
    output logic [COUNT_WIDTH-1:0] xfer_count
);
    logic [1:0]             occ_q, occ_d;
    logic                   inf_q;
    logic                   head_q, tail_q;
    logic [DATA_WIDTH-1:0]  mem_q [2];
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic                   pop, rd;
    logic [2:0]             level;

    assign pop = (occ_q != 2'd0) & bus.m_ready;

    // Occupancy after this edge counting the in-flight word; a pop can free a slot
    // the same cycle, which is what keeps 1 word/cycle in steady state.
    always_comb begin
        level = {1'b0, occ_q} + {2'b00, inf_q} - {2'b00, pop};
        occ_d = level[1:0];
        rd    = ~reset & ~bus.fifo_empty & (level < 3'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q    <= '0;
            inf_q    <= 1'b0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            cnt_q    <= '0;
        end else begin
            if (inf_q) begin
                mem_q[tail_q] <= bus.fifo_rd_data;
                tail_q        <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
                cnt_q  <= cnt_q + 1'b1;
            end
            occ_q <= occ_d;
            inf_q <= rd;
        end
    end

    assign bus.fifo_rd = rd;
    assign bus.m_valid = (occ_q != 2'd0);
    assign bus.m_data  = mem_q[head_q];
    assign xfer_count  = cnt_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench: behavioural FIFO model feeding the reader, scoreboard queue of expected
// stream words, independent monitor checking order, hold rules and the counter.
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] xfer_count;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    byte unsigned fifo_q[$];
    byte unsigned exp_q[$];
    bit           hold_empty;
    int           n_chk, n_fail;
    int           exp_cnt;
    bit           prev_stall;
    logic [DW-1:0] prev_data;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input byte unsigned w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIFO model: pop sampled at negedge, data presented just after the edge
    initial begin
        bit rd_s;
        bus.fifo_rd_data = '0;
        bus.fifo_empty   = 1'b1;
        forever begin
            @(negedge clk);
            rd_s = bus.fifo_rd && !reset;
            @(posedge clk);
            #1;
            if (rd_s && !reset) begin
                if (fifo_q.size() == 0) chk("pop_from_empty_fifo", 1, 0);
                else bus.fifo_rd_data = fifo_q.pop_front();
            end
            #1;
            bus.fifo_empty = (fifo_q.size() == 0) || hold_empty;
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                chk("occ_plus_inf_le_2", (int'(dut.occ_q) + int'(dut.inf_q) <= 2) ? 1 : 0, 1);
                if (bus.fifo_rd) chk("fifo_rd_while_empty", int'(bus.fifo_empty), 0);
                if (prev_stall) begin
                    chk("valid_hold", int'(bus.m_valid), 1);
                    chk("data_hold", int'(bus.m_data), int'(prev_data));
                end
                chk("xfer_count", int'(xfer_count), exp_cnt % (1 << CW));
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_word", int'(bus.m_data), -1);
                    else chk("stream_data", int'(bus.m_data), int'(exp_q.pop_front()));
                    exp_cnt++;
                end
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_data  = bus.m_data;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt, k;
        bit  ok, just;
        reset      = 1'b1;
        hold_empty = 1'b0;
        bus.m_ready = 1'b0;
        exp_cnt    = 0;

        // T1: reset held while the FIFO reports data
        fifo_q.push_back(8'h5A);
        repeat (3) @(negedge clk);
        chk("t1_fifo_empty_low", int'(bus.fifo_empty), 0);
        chk("t1_fifo_rd", int'(bus.fifo_rd), 0);
        chk("t1_m_valid", int'(bus.m_valid), 0);
        chk("t1_m_data", int'(bus.m_data), 0);
        chk("t1_xfer_count", int'(xfer_count), 0);
        tick();
        fifo_q.delete();
        tick();
        reset = 1'b0;
        bus.m_ready = 1'b1;
        repeat (2) tick();

        // T2: single word latency
        push(8'hA5);
        @(negedge clk);
        chk("t2_rd_cycle_n", int'(bus.fifo_rd), 1);
        chk("t2_valid_n", int'(bus.m_valid), 0);
        @(negedge clk);
        chk("t2_valid_n1", int'(bus.m_valid), 0);
        chk("t2_rd_n1", int'(bus.fifo_rd), 0);
        @(negedge clk);
        chk("t2_valid_n2", int'(bus.m_valid), 1);
        chk("t2_data_n2", int'(bus.m_data), 8'hA5);
        @(negedge clk);
        chk("t2_count", int'(xfer_count), 1);
        chk("t2_valid_after", int'(bus.m_valid), 0);

        // T3: back-to-back stream
        tick();
        for (int i = 1; i <= 8; i++) push(byte'(i));
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = bus.m_valid;
        end
        chk("t3_valid_seen", int'(ok), 1);
        for (int i = 1; i <= 8; i++) begin
            chk("t3_valid_run", int'(bus.m_valid), 1);
            chk("t3_data_run", int'(bus.m_data), i);
            @(negedge clk);
        end
        chk("t3_count", int'(xfer_count), 9 % (1 << CW));

        // T4: backpressure
        tick();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(byte'(8'h10 + i));
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.fifo_rd) cnt++;
        end
        chk("t4_rd_pulses", cnt, 2);
        chk("t4_valid_held", int'(bus.m_valid), 1);
        chk("t4_data_held", int'(bus.m_data), 8'h10);
        tick();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_valid_run", int'(bus.m_valid), 1);
            chk("t4_data_run", int'(bus.m_data), 8'h10 + i);
        end

        // T5: random empty flag and backpressure
        for (int c = 0; c < 1000; c++) begin
            tick();
            if ($urandom_range(0, 2) == 0) push(byte'($urandom_range(0, 255)));
            hold_empty  = ($urandom_range(0, 3) == 0);
            bus.m_ready = $urandom_range(0, 1) == 1;
        end
        tick();
        hold_empty  = 1'b0;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 2000 && (exp_q.size() != 0 || bus.m_valid); c++) @(negedge clk);
        chk("t5_drained", exp_q.size(), 0);
        chk("t5_fifo_empty", fifo_q.size(), 0);

        // T6a: reset with a full skid buffer
        tick();
        bus.m_ready = 1'b0;
        push(8'h30);
        push(8'h31);
        push(8'h32);
        repeat (5) @(negedge clk);
        chk("t6_valid_before_reset", int'(bus.m_valid), 1);
        tick();
        reset = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        exp_cnt = 0;
        #1;
        chk("t6_valid_in_reset", int'(bus.m_valid), 0);
        chk("t6_count_in_reset", int'(xfer_count), 0);
        repeat (2) tick();
        reset = 1'b0;

        // T6b: counter wrap, first word after reset is the new head
        tick();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(byte'(8'h80 + i));
        k = 0;
        just = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (just && k >= 15) chk("t6_xfer_wrap", int'(xfer_count), k % 16);
            just = 1'b0;
            if (k == 17) break;
            if (bus.m_valid && bus.m_ready) begin
                if (k == 0) chk("t6_first_after_reset", int'(bus.m_data), 8'h80);
                k++;
                just = 1'b1;
            end
        end
        chk("t6_transfers", k, 17);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
